// File: rtl/matrix_result_serializer.sv
// Snapshots a complete matrix result and streams it row-major over a valid/ready port.
// Optional MATRIX_SER_ROW_LAST_EN adds row_last_o, driven by a column counter.
module matrix_result_serializer #(
  parameter  int C_DATA_WIDTH = 67,
  parameter  int A_ROWS       = 10,
  parameter  int B_COLUMNS    = 4,
  localparam int N            = A_ROWS * B_COLUMNS,
  localparam int IDX_W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  input  logic [C_DATA_WIDTH-1:0] c_i [0:N-1],
  output logic [C_DATA_WIDTH-1:0] data_o,
  output logic                    data_valid_o,
  input  logic                    data_ready_i,
  output logic [IDX_W-1:0]        idx_o,
  output logic                    last_o,
`ifdef MATRIX_SER_ROW_LAST_EN
  output logic                    row_last_o,
`endif
  output logic                    busy_o,
  output logic                    overrun_o
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    overrun_q, overrun_d;
  logic                    load;
  logic                    handshake;
  logic                    at_last;
  logic [C_DATA_WIDTH-1:0] snap_q [0:N-1];

`ifdef MATRIX_SER_ROW_LAST_EN
  localparam int COL_W = (B_COLUMNS > 1) ? $clog2(B_COLUMNS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(B_COLUMNS - 1);
  logic [COL_W-1:0] col_q, col_d;
`endif

  assign at_last   = (idx_q == IDX_LAST);
  assign handshake = (state_q == STREAM) && data_ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  // Snapshot storage has no reset; it is only observable once a load has happened.
  always_ff @(posedge clk_i) begin
    if (load && !reset_i) begin
      snap_q <= c_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (valid_i) begin
          load    = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (handshake && at_last) begin
          // A new result landing on the final handshake chains straight into the next stream.
          idx_d = '0;
          if (valid_i) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (handshake) begin
            idx_d = idx_q + 1'b1;
          end
          if (valid_i) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign data_valid_o = (state_q == STREAM);
  assign busy_o       = (state_q == STREAM);
  assign data_o       = data_valid_o ? snap_q[idx_q] : '0;
  assign idx_o        = data_valid_o ? idx_q : '0;
  assign last_o       = data_valid_o && at_last;
  assign overrun_o    = overrun_q;

`ifdef MATRIX_SER_ROW_LAST_EN
  // Column counter tracks idx % B_COLUMNS and restarts whenever idx does.
  always_comb begin
    col_d = col_q;
    if (state_q != STREAM || (handshake && at_last)) begin
      col_d = '0;
    end else if (handshake) begin
      col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end

  assign row_last_o = data_valid_o && (col_q == COL_LAST);
`endif

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed self-checking bench for matrix_result_serializer (10x4 result, 67-bit elements).
module tb_matrix_result_serializer;
  localparam int W  = 67;
  localparam int N  = 40;
  localparam int IW = 6;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic          data_ready_i;
  logic [W-1:0]  c_i [0:N-1];
  logic [W-1:0]  data_o;
  logic          data_valid_o;
  logic [IW-1:0] idx_o;
  logic          last_o;
  logic          busy_o;
  logic          overrun_o;
`ifdef MATRIX_SER_ROW_LAST_EN
  logic          row_last_o;
`endif

  int checks = 0;
  int errors = 0;

  matrix_result_serializer dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .valid_i      (valid_i),
    .c_i          (c_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .idx_o        (idx_o),
    .last_o       (last_o),
`ifdef MATRIX_SER_ROW_LAST_EN
    .row_last_o   (row_last_o),
`endif
    .busy_o       (busy_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic load_c(input int base);
    for (int k = 0; k < N; k++) c_i[k] = W'(base + k);
  endtask

  task automatic test_reset();
    reset_i = 1'b1; valid_i = 1'b0; data_ready_i = 1'b0;
    load_c(0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({data_valid_o, busy_o, last_o, overrun_o, idx_o, data_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got dv=%b busy=%b last=%b ovr=%b idx=%0d data=%h, want all 0",
               data_valid_o, busy_o, last_o, overrun_o, idx_o, data_o);
    end
    reset_i = 1'b0;
    data_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({data_valid_o, busy_o, idx_o, data_o} !== '0) begin
      errors++;
      $display("[TB] FAIL idle_ready_no_effect: got dv=%b busy=%b idx=%0d data=%h, want 0",
               data_valid_o, busy_o, idx_o, data_o);
    end
  endtask

  task automatic test_basic_stream();
    @(negedge clk_i);
    load_c(1); valid_i = 1'b1; data_ready_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      checks++;
      if ({data_valid_o, busy_o, last_o, idx_o, data_o} !== {1'b1, 1'b1, (i == N-1), IW'(i), W'(i + 1)}) begin
        errors++;
        $display("[TB] FAIL basic_elem%0d: got dv=%b busy=%b last=%b idx=%0d data=%0d, want dv=1 busy=1 last=%b idx=%0d data=%0d",
                 i, data_valid_o, busy_o, last_o, idx_o, data_o, (i == N-1), i, i + 1);
      end
    end
    @(negedge clk_i);
    checks++;
    if ({data_valid_o, busy_o, last_o, idx_o, data_o} !== '0) begin
      errors++;
      $display("[TB] FAIL basic_idle_after: got dv=%b busy=%b last=%b idx=%0d data=%h, want all 0",
               data_valid_o, busy_o, last_o, idx_o, data_o);
    end
  endtask

  task automatic test_stall();
    logic [3:0] pat;
    int count;
    int cyc;
    pat = 4'b1001;
    count = 0;
    cyc = 0;
    @(negedge clk_i);
    load_c(1); valid_i = 1'b1; data_ready_i = 1'b0;
    while (count < N && cyc < 400) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      checks++;
      if ({data_valid_o, idx_o, data_o} !== {1'b1, IW'(count), W'(count + 1)}) begin
        errors++;
        $display("[TB] FAIL stall_cyc%0d: got dv=%b idx=%0d data=%0d, want dv=1 idx=%0d data=%0d",
                 cyc, data_valid_o, idx_o, data_o, count, count + 1);
      end
      data_ready_i = pat[cyc % 4];
      if (data_ready_i) count++;
      cyc++;
    end
    if (count < N) begin
      checks++; errors++;
      $display("[TB] FAIL stall_timeout: got %0d handshakes, want %0d", count, N);
    end
    @(negedge clk_i);
    data_ready_i = 1'b1;
    checks++;
    if ({data_valid_o, busy_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL stall_idle_after: got dv=%b busy=%b, want 0 0", data_valid_o, busy_o);
    end
  endtask

  task automatic test_overrun();
    @(negedge clk_i);
    load_c(1); valid_i = 1'b1; data_ready_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      checks++;
      if ({data_valid_o, overrun_o, idx_o, data_o} !== {1'b1, (i >= 6), IW'(i), W'(i + 1)}) begin
        errors++;
        $display("[TB] FAIL overrun_elem%0d: got dv=%b ovr=%b idx=%0d data=%0d, want dv=1 ovr=%b idx=%0d data=%0d",
                 i, data_valid_o, overrun_o, idx_o, data_o, (i >= 6), i, i + 1);
      end
      if (i == 5) begin
        for (int k = 0; k < N; k++) c_i[k] = W'(8'hFF);
        valid_i = 1'b1;
      end
    end
    @(negedge clk_i);
    checks++;
    if ({data_valid_o, overrun_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL overrun_sticky: got dv=%b ovr=%b, want dv=0 ovr=1", data_valid_o, overrun_o);
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    load_c(1); valid_i = 1'b1; data_ready_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      if (i == N-1) begin
        load_c(100);
        valid_i = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      checks++;
      if ({data_valid_o, busy_o, overrun_o, last_o, idx_o, data_o} !==
          {1'b1, 1'b1, 1'b0, (j == N-1), IW'(j), W'(100 + j)}) begin
        errors++;
        $display("[TB] FAIL b2b_elem%0d: got dv=%b busy=%b ovr=%b last=%b idx=%0d data=%0d, want dv=1 busy=1 ovr=0 last=%b idx=%0d data=%0d",
                 j, data_valid_o, busy_o, overrun_o, last_o, idx_o, data_o, (j == N-1), j, 100 + j);
      end
    end
    @(negedge clk_i);
    checks++;
    if ({data_valid_o, busy_o, overrun_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL b2b_idle_after: got dv=%b busy=%b ovr=%b, want 0 0 0", data_valid_o, busy_o, overrun_o);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk_i);
    load_c(1); valid_i = 1'b1; data_ready_i = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      if (i == 3) valid_i = 1'b1;
    end
    checks++;
    if ({overrun_o, idx_o, data_o} !== {1'b1, IW'(17), W'(18)}) begin
      errors++;
      $display("[TB] FAIL midreset_pre: got ovr=%b idx=%0d data=%0d, want ovr=1 idx=17 data=18",
               overrun_o, idx_o, data_o);
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    checks++;
    if ({data_valid_o, busy_o, last_o, overrun_o, idx_o, data_o} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_post: got dv=%b busy=%b last=%b ovr=%b idx=%0d data=%h, want all 0",
               data_valid_o, busy_o, last_o, overrun_o, idx_o, data_o);
    end
    load_c(300);
    reset_i = 1'b1; valid_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0; valid_i = 1'b0;
    checks++;
    if ({data_valid_o, busy_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_priority: got dv=%b busy=%b, want 0 0", data_valid_o, busy_o);
    end
    load_c(200); valid_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      checks++;
      if ({data_valid_o, idx_o, data_o} !== {1'b1, IW'(i), W'(200 + i)}) begin
        errors++;
        $display("[TB] FAIL restart_elem%0d: got dv=%b idx=%0d data=%0d, want dv=1 idx=%0d data=%0d",
                 i, data_valid_o, idx_o, data_o, i, 200 + i);
      end
    end
    @(negedge clk_i);
  endtask

`ifdef MATRIX_SER_ROW_LAST_EN
  task automatic test_row_last();
    int pulses;
    pulses = 0;
    @(negedge clk_i);
    load_c(1); valid_i = 1'b1; data_ready_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      if (row_last_o) pulses++;
      checks++;
      if (row_last_o !== ((i % 4) == 3)) begin
        errors++;
        $display("[TB] FAIL row_last_idx%0d: got %b, want %b", i, row_last_o, ((i % 4) == 3));
      end
    end
    @(negedge clk_i);
    checks++;
    if (pulses != 10 || row_last_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL row_last_count: got %0d pulses (idle value %b), want 10 (0)", pulses, row_last_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_stream();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
`ifdef MATRIX_SER_ROW_LAST_EN
    test_row_last();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
